// File: rtl/noc_pkg.sv
// Shared definitions for the router: default flit width, the RTS/DCTS
// handshake state encoding and the router port index constants that the
// input FIFOs, the arbiter and the crossbar all agree on.
package noc_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

    // Router port indices
    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

endpackage

// File: rtl/noc_fifo_mem.sv
// Storage array for the router input FIFO.
// A DEPTH x DATA_WIDTH register file with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset; occupancy is
// tracked by the owner, so stale entries are never observed as valid data.
// Ports:
//   clk      - clock, write happens on posedge
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - data to store
//   rd_addr  - read index
//   rd_data  - mem[rd_addr], combinational
module noc_fifo_mem #(
    parameter int DATA_WIDTH = noc_pkg::DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/noc_rx_input_fifo.sv
// Receiver side of the RTS/DCTS link for one router input port.
// The upstream sender raises RTS with a flit on RX; a two-state handshake
// FSM answers with a single-cycle registered DCTS pulse and captures the flit
// into a small circular FIFO. The local arbiter/crossbar drains the FIFO via
// read_en / empty, seeing the head entry on Data_out.
// Ports:
//   clk      - clock
//   rst      - synchronous reset, active low
//   RX       - incoming flit, stable while RTS is high
//   RTS      - upstream request-to-send
//   DCTS     - accept pulse back to upstream
//   read_en  - pop head entry (ignored while empty)
//   Data_out - head entry
//   empty    - no entries stored
//   full     - DEPTH entries stored
//   count    - current occupancy
module noc_rx_input_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    RX,
    input  logic                     RTS,
    output logic                     DCTS,
    input  logic                     read_en,
    output logic [DATA_WIDTH-1:0]    Data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    hs_state_t        state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A flit is only captured if the sender still holds RTS during the ACK
    // cycle; a dropped RTS there is a protocol violation and is discarded.
    assign wr_en = (state == HS_ACK) && RTS;
    assign rd_en = read_en && !empty;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // Handshake FSM. DCTS is registered alongside the state so it is high
    // exactly while in HS_ACK. The full check happens at decision time; the
    // write lands one cycle later and reads can only free space meanwhile.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HS_IDLE;
            DCTS  <= 1'b0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (RTS && (count < DEPTH_CNT)) begin
                        state <= HS_ACK;
                        DCTS  <= 1'b1;
                    end else begin
                        DCTS  <= 1'b0;
                    end
                end
                HS_ACK: begin
                    state <= HS_IDLE;
                    DCTS  <= 1'b0;
                end
                default: begin
                    state <= HS_IDLE;
                    DCTS  <= 1'b0;
                end
            endcase
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count is kept
    // separately so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    noc_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (RX),
        .rd_addr (rd_ptr),
        .rd_data (Data_out)
    );

endmodule

// File: tb/tb_noc_rx_input_fifo.sv
// Directed bench for noc_rx_input_fifo with hand-computed expected values.
module tb_noc_rx_input_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] RX;
    logic        RTS;
    logic        DCTS;
    logic        read_en;
    logic [31:0] Data_out;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    int checks_total  = 0;
    int checks_passed = 0;

    noc_rx_input_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .RTS      (RTS),
        .DCTS     (DCTS),
        .read_en  (read_en),
        .Data_out (Data_out),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle; inputs are driven and outputs
    // sampled 1 time unit after the posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Send one flit: hold RTS until DCTS (bounded), keep it through the
    // write edge, then drop it.
    task automatic applyStimulus(input logic [31:0] data);
        int waited;
        RX  = data;
        RTS = 1'b1;
        waited = 0;
        step();
        while (!DCTS && waited < 8) begin
            step();
            waited++;
        end
        if (!DCTS) begin
            checkOutput("dcts_timeout", {31'b0, DCTS}, 32'd1);
        end
        step();
        RTS = 1'b0;
    endtask

    task automatic popOne();
        read_en = 1'b1;
        step();
        read_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        RX      = 32'h0;
        RTS     = 1'b0;
        read_en = 1'b0;

        // Test 1: reset with RTS held, then release
        rst = 1'b0;
        RTS = 1'b1;
        RX  = 32'hA5A5_0001;
        step();
        step();
        checkOutput("rst_dcts",  {31'b0, DCTS},  32'd0);
        checkOutput("rst_empty", {31'b0, empty}, 32'd1);
        checkOutput("rst_full",  {31'b0, full},  32'd0);
        checkOutput("rst_count", {29'b0, count}, 32'd0);
        rst = 1'b1;
        checkOutput("rel_dcts0", {31'b0, DCTS}, 32'd0);
        step();
        checkOutput("rel_dcts1", {31'b0, DCTS}, 32'd1);

        // Test 2: the same flit completes on the write edge
        step();
        RTS = 1'b0;
        checkOutput("single_dcts",  {31'b0, DCTS},  32'd0);
        checkOutput("single_count", {29'b0, count}, 32'd1);
        checkOutput("single_data",  Data_out,       32'hA5A5_0001);
        checkOutput("single_empty", {31'b0, empty}, 32'd0);
        popOne();
        checkOutput("single_pop", {29'b0, count}, 32'd0);

        // Test 3: fill, stall the fifth flit, pop once, then drain in order
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(32'(i));
        end
        checkOutput("fill_full",  {31'b0, full},  32'd1);
        checkOutput("fill_count", {29'b0, count}, 32'd4);
        RX  = 32'd5;
        RTS = 1'b1;
        begin
            int seen_dcts;
            seen_dcts = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (DCTS) seen_dcts++;
            end
            checkOutput("stall_dcts", 32'(seen_dcts), 32'd0);
        end
        checkOutput("stall_head", Data_out, 32'd1);
        popOne();
        checkOutput("stall_pop_count", {29'b0, count}, 32'd3);
        checkOutput("stall_pop_head",  Data_out,       32'd2);
        step();
        checkOutput("unstall_dcts", {31'b0, DCTS}, 32'd1);
        step();
        RTS = 1'b0;
        checkOutput("unstall_count", {29'b0, count}, 32'd4);
        for (int i = 2; i <= 5; i++) begin
            checkOutput($sformatf("drain_%0d", i), Data_out, 32'(i));
            popOne();
        end
        checkOutput("drain_empty", {31'b0, empty}, 32'd1);

        // Test 4: write and pop on the same edge with count==1
        applyStimulus(32'h11);
        checkOutput("conc_pre_head", Data_out, 32'h11);
        RX  = 32'h22;
        RTS = 1'b1;
        step();
        checkOutput("conc_dcts", {31'b0, DCTS}, 32'd1);
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        RTS     = 1'b0;
        checkOutput("conc_count", {29'b0, count}, 32'd1);
        checkOutput("conc_head",  Data_out,       32'h22);
        popOne();

        // Test 5: underflow is ignored, RTS drop in HS_ACK writes nothing
        popOne();
        checkOutput("uflow_count", {29'b0, count}, 32'd0);
        checkOutput("uflow_empty", {31'b0, empty}, 32'd1);
        applyStimulus(32'h33);
        checkOutput("uflow_head",  Data_out,       32'h33);
        checkOutput("uflow_count1", {29'b0, count}, 32'd1);
        RX  = 32'h44;
        RTS = 1'b1;
        step();
        checkOutput("viol_dcts", {31'b0, DCTS}, 32'd1);
        RTS = 1'b0;
        step();
        checkOutput("viol_count", {29'b0, count}, 32'd1);
        checkOutput("viol_head",  Data_out,       32'h33);
        step();
        checkOutput("viol_count2", {29'b0, count}, 32'd1);
        popOne();

        // Test 6: reset during HS_ACK with three entries stored
        applyStimulus(32'h61);
        applyStimulus(32'h62);
        applyStimulus(32'h63);
        checkOutput("mid_count3", {29'b0, count}, 32'd3);
        RX  = 32'h64;
        RTS = 1'b1;
        step();
        checkOutput("mid_dcts", {31'b0, DCTS}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        RTS = 1'b0;
        checkOutput("mid_rst_dcts",  {31'b0, DCTS},  32'd0);
        checkOutput("mid_rst_count", {29'b0, count}, 32'd0);
        checkOutput("mid_rst_empty", {31'b0, empty}, 32'd1);
        step();
        checkOutput("mid_rst_count2", {29'b0, count}, 32'd0);
        applyStimulus(32'h65);
        checkOutput("post_rst_head",  Data_out,       32'h65);
        checkOutput("post_rst_count", {29'b0, count}, 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
